// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline stall/flush sequencer with trap/mret drain and PC redirect
module pipe_stage_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int XLEN         = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_use_hazard,
    input  logic            ifetch_busy,
    input  logic            dmem_busy,
    input  logic            branch_redirect,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [15:0]     trap_cause,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            pc_en,
    output logic            en_fd,
    output logic            en_de,
    output logic            en_em,
    output logic            en_mw,
    output logic            flush_fd,
    output logic            flush_de,
    output logic            flush_em,
    output logic            flush_mw,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] epc_out,
    output logic [15:0]     cause_out,
    output logic            busy
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, REDIRECT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            live_q;
    logic [XLEN-1:0] target_q, hold_q, epc_q;
    logic [15:0]     cause_q;
    logic            take_trap, take_mret;
    logic [3:0]      en_v, flush_v;

    // live_q keeps the reset-time output pattern until the first clock edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= 4'd0;
            live_q   <= 1'b0;
            target_q <= '0;
            hold_q   <= '0;
            epc_q    <= '0;
            cause_q  <= 16'd0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_trap) begin
                epc_q    <= trap_pc;
                cause_q  <= trap_cause;
                target_q <= mtvec;
            end else if (take_mret) begin
                target_q <= mepc;
            end
            if (redirect_valid) begin
                hold_q <= redirect_pc;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_en          = 1'b0;
        en_v           = 4'b0000;
        flush_v        = 4'b0000;
        redirect_valid = 1'b0;
        redirect_pc    = hold_q;
        take_trap      = 1'b0;
        take_mret      = 1'b0;
        if (!live_q) begin
            flush_v = 4'b1111;
            state_d = RUN;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    // the MEM_WAIT exit cycle is decoded exactly like RUN
                    if (!(state_q == MEM_WAIT && dmem_busy)) begin
                        state_d = RUN;
                        if (trap_valid || mret_valid) begin
                            state_d   = DRAIN;
                            flush_v   = 4'b1111;
                            take_trap = trap_valid;
                            take_mret = mret_valid && !trap_valid;
                        end else if (dmem_busy) begin
                            state_d = MEM_WAIT;
                        end else if (branch_redirect) begin
                            redirect_valid = 1'b1;
                            redirect_pc    = branch_target;
                            flush_v        = 4'b1100;
                            en_v           = 4'b0011;
                            pc_en          = 1'b1;
                        end else if (load_use_hazard) begin
                            flush_v = 4'b0100;
                            en_v    = 4'b0011;
                        end else if (ifetch_busy) begin
                            flush_v = 4'b1000;
                            en_v    = 4'b0111;
                        end else begin
                            en_v  = 4'b1111;
                            pc_en = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    flush_v = 4'b1111;
                    if (!dmem_busy) begin
                        if (cnt_q == 4'(DRAIN_CYCLES - 1)) begin
                            cnt_d   = 4'd0;
                            state_d = REDIRECT;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                    pc_en          = 1'b1;
                    flush_v        = 4'b1111;
                    state_d        = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign {en_fd, en_de, en_em, en_mw}             = en_v;
    assign {flush_fd, flush_de, flush_em, flush_mw} = flush_v;
    assign epc_out   = epc_q;
    assign cause_out = cause_q;
    assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - self-checking bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;
    localparam int DC = 2;
    localparam int XL = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_use_hazard, ifetch_busy, dmem_busy, branch_redirect;
    logic [XL-1:0] branch_target, trap_pc, mtvec, mepc;
    logic          trap_valid, mret_valid;
    logic [15:0]   trap_cause;
    logic          pc_en, en_fd, en_de, en_em, en_mw;
    logic          flush_fd, flush_de, flush_em, flush_mw;
    logic          redirect_valid, busy;
    logic [XL-1:0] redirect_pc, epc_out;
    logic [15:0]   cause_out;

    pipe_stage_ctrl #(.DRAIN_CYCLES(DC), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .load_use_hazard(load_use_hazard), .ifetch_busy(ifetch_busy), .dmem_busy(dmem_busy),
        .branch_redirect(branch_redirect), .branch_target(branch_target),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mtvec(mtvec), .mepc(mepc),
        .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mw(flush_mw),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .epc_out(epc_out), .cause_out(cause_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // model: phase 0 running, 1 waiting on memory, 2 draining, 3 redirecting;
    // m_quiet counts the idle (non-busy) drain cycles still owed
    int            m_ph, n_ph, m_quiet, n_quiet;
    logic          m_live, n_live;
    logic [XL-1:0] m_target, n_target, m_hold, n_hold, m_epc, n_epc;
    logic [15:0]   m_cause, n_cause;
    logic [3:0]    e_en, e_fl;
    logic          e_pc, e_rv;
    logic [XL-1:0] e_rpc;

    task automatic model_reset();
        m_ph = 0; m_quiet = DC; m_live = 1'b0;
        m_target = '0; m_hold = '0; m_epc = '0; m_cause = '0;
    endtask

    initial model_reset();
    always @(negedge rst) model_reset();

    always @(negedge clk) begin
        e_en = 4'b0000; e_fl = 4'b0000; e_pc = 1'b0; e_rv = 1'b0;
        if (!rst) model_reset();
        n_ph = m_ph; n_quiet = m_quiet; n_live = 1'b1;
        n_target = m_target; n_hold = m_hold; n_epc = m_epc; n_cause = m_cause;
        e_rpc = m_hold;
        if (!rst || !m_live) begin
            e_fl = 4'b1111;
        end else if (m_ph == 1 && dmem_busy) begin
            n_ph = 1;
        end else if (m_ph <= 1) begin
            n_ph = 0;
            if (trap_valid || mret_valid) begin
                e_fl = 4'b1111; n_ph = 2; n_quiet = DC;
                if (trap_valid) begin
                    n_epc = trap_pc; n_cause = trap_cause; n_target = mtvec;
                end else begin
                    n_target = mepc;
                end
            end else if (dmem_busy) begin
                n_ph = 1;
            end else if (branch_redirect) begin
                e_rv = 1'b1; e_rpc = branch_target; e_fl = 4'b1100; e_en = 4'b0011; e_pc = 1'b1;
            end else if (load_use_hazard) begin
                e_fl = 4'b0100; e_en = 4'b0011;
            end else if (ifetch_busy) begin
                e_fl = 4'b1000; e_en = 4'b0111;
            end else begin
                e_en = 4'b1111; e_pc = 1'b1;
            end
        end else if (m_ph == 2) begin
            e_fl = 4'b1111;
            if (!dmem_busy) begin
                n_quiet = m_quiet - 1;
                if (n_quiet == 0) begin
                    n_ph = 3; n_quiet = DC;
                end
            end
        end else begin
            e_rv = 1'b1; e_rpc = m_target; e_pc = 1'b1; e_fl = 4'b1111; n_ph = 0;
        end
        if (e_rv) n_hold = e_rpc;
        chk("m_en", {en_fd, en_de, en_em, en_mw}, e_en);
        chk("m_flush", {flush_fd, flush_de, flush_em, flush_mw}, e_fl);
        chk("m_pc_en", pc_en, e_pc);
        chk("m_rv", redirect_valid, e_rv);
        chk("m_rpc", redirect_pc, e_rpc);
        chk("m_busy", busy, (m_ph != 0));
        chk("m_epc", epc_out, m_epc);
        chk("m_cause", cause_out, m_cause);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ph = n_ph; m_quiet = n_quiet; m_live = n_live;
            m_target = n_target; m_hold = n_hold; m_epc = n_epc; m_cause = n_cause;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_use_hazard = 0; ifetch_busy = 0; dmem_busy = 0; branch_redirect = 0;
        trap_valid = 0; mret_valid = 0;
    endtask

    // called in the first DRAIN cycle; counts drain cycles until the redirect strobe
    task automatic run_drain(input int busy_cycles, output int drain_n,
                             output logic [XL-1:0] rpc, output logic seen);
        drain_n = 0; seen = 1'b0; rpc = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            dmem_busy = (i < busy_cycles);
            #1;
            if (redirect_valid) begin
                seen = 1'b1;
                rpc  = redirect_pc;
            end else if (busy) begin
                drain_n++;
            end
            tick();
        end
        dmem_busy = 0;
    endtask

    int            rv_cnt, dn;
    logic          seen;
    logic [XL-1:0] rpc;

    initial begin
        clear_inputs();
        branch_target = '0; trap_pc = '0; trap_cause = '0;
        mtvec = 64'h8000_0000; mepc = 64'h8000_2000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_flush_fd", flush_fd, 1'b1);
        chk("rst_en_fd", en_fd, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 64'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("pre_edge_en_fd", en_fd, 1'b0);
        tick();
        chk("first_edge_en", {en_fd, en_de, en_em, en_mw}, 4'hF);
        chk("first_edge_pc_en", pc_en, 1'b1);
        tick();

        load_use_hazard = 1;
        #1;
        chk("lu_pc_en", pc_en, 1'b0);
        chk("lu_en_fd", en_fd, 1'b0);
        chk("lu_flush_de", flush_de, 1'b1);
        chk("lu_en_em", en_em, 1'b1);
        tick();
        load_use_hazard = 0;
        #1 chk("lu_after_en", {en_fd, en_de, en_em, en_mw}, 4'hF);
        tick();

        rv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            dmem_busy = 1; branch_redirect = (i == 1); branch_target = 64'h8000_0100;
            #1;
            chk("mw_en", {en_fd, en_de, en_em, en_mw}, 4'h0);
            if (redirect_valid) rv_cnt++;
            tick();
        end
        dmem_busy = 0; branch_redirect = 0;
        chk("mw_no_redirect", rv_cnt, 0);
        tick();

        branch_redirect = 1; branch_target = 64'h8000_0100;
        #1;
        chk("br_rv", redirect_valid, 1'b1);
        chk("br_pc", redirect_pc, 64'h8000_0100);
        chk("br_flush", {flush_fd, flush_de}, 2'b11);
        tick();
        branch_redirect = 0;
        #1 chk("br_hold_pc", redirect_pc, 64'h8000_0100);
        ifetch_busy = 1;
        tick();
        ifetch_busy = 0; branch_redirect = 1; load_use_hazard = 1; branch_target = 64'h8000_0200;
        tick();
        clear_inputs();
        tick();

        trap_valid = 1; trap_pc = 64'h8000_0040; trap_cause = 16'h0004;
        tick();
        trap_valid = 0;
        #1;
        chk("trap_epc", epc_out, 64'h8000_0040);
        chk("trap_cause", cause_out, 16'h0004);
        run_drain(2, dn, rpc, seen);
        chk("trap_drain_len", dn, 4);
        chk("trap_redirect_seen", seen, 1'b1);
        chk("trap_redirect_pc", rpc, 64'h8000_0000);
        #1 chk("trap_redirect_once", redirect_valid, 1'b0);
        tick();

        mret_valid = 1;
        tick();
        mret_valid = 0;
        run_drain(0, dn, rpc, seen);
        chk("mret_redirect_pc", rpc, 64'h8000_2000);
        chk("mret_drain_len", dn, 2);
        tick();

        trap_valid = 1; mret_valid = 1; trap_pc = 64'h8000_0080; trap_cause = 16'h0008;
        tick();
        clear_inputs();
        #1 chk("both_cause", cause_out, 16'h0008);
        run_drain(0, dn, rpc, seen);
        chk("both_redirect_pc", rpc, 64'h8000_0000);
        tick();

        trap_valid = 1; trap_pc = 64'h8000_00c0; trap_cause = 16'h0002;
        tick();
        trap_valid = 0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_flush", {flush_fd, flush_de, flush_em, flush_mw}, 4'hF);
        chk("mid_rst_en", {en_fd, en_de, en_em, en_mw}, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rv", redirect_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();
        chk("post_rst_en", {en_fd, en_de, en_em, en_mw}, 4'hF);
        chk("post_rst_pc_en", pc_en, 1'b1);
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (redirect_valid) rv_cnt++;
            tick();
        end
        chk("post_rst_no_redirect", rv_cnt, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Central stall/flush sequencer for the in-order pipeline stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Generates per-stage enable and flush (bubble) strobes from hazard, memory-busy, branch and trap inputs.
- Owns the trap sequence: drain, then redirect the PC to the trap vector. Sequences mret the same way.
- Sits beside the register chain. Its flush_* outputs drive the stage registers' clear inputs; its en_* outputs drive their enable inputs.

Parameters:
- DRAIN_CYCLES, 2, idle cycles held after a trap before redirect (1..15).
- XLEN, 64, PC width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- load_use_hazard  in  1  decode needs a result still in execute from a load
- ifetch_busy  in  1  instruction fetch not yet returned
- dmem_busy  in  1  data memory access outstanding in the memory stage
- branch_redirect  in  1  execute resolved a taken or mispredicted branch
- branch_target  in  XLEN  target for branch_redirect
- trap_valid  in  1  exception committed at writeback
- trap_pc  in  XLEN  PC of the trapping instruction
- trap_cause  in  16  exception bitmap from the pipeline
- mret_valid  in  1  mret committed at writeback
- mtvec  in  XLEN  trap vector base
- mepc  in  XLEN  return PC for mret
- pc_en  out  1  fetch PC register enable
- en_fd, en_de, en_em, en_mw  out  1 each  stage register enables
- flush_fd, flush_de, flush_em, flush_mw  out  1 each  stage register clear
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- epc_out  out  XLEN  latched trap_pc
- cause_out  out  16  latched trap_cause
- busy  out  1  high in any state other than RUN

Behaviour:
- Reset (rst=0, async):
  - State goes to RUN; the drain counter goes to 0.
  - All en_* and pc_en are 0; all flush_* are 1.
  - redirect_valid is 0; redirect_pc, epc_out and cause_out are 0.
- After reset deassertion, the outputs take their RUN values on the next clk edge.
- State register:
  - Registered states: RUN, MEM_WAIT, DRAIN, REDIRECT.
  - All outputs are decoded combinationally from the state and the current inputs, so there is zero-cycle latency from a hazard input to its stall.
- RUN, evaluated in priority order (highest first):
  1. trap_valid or mret_valid:
     - Next state DRAIN.
     - flush_fd, flush_de, flush_em, flush_mw = 1; all en_* = 0; pc_en = 0.
     - On trap_valid, latch epc_out <= trap_pc and cause_out <= trap_cause.
     - Latch the redirect target: mtvec for a trap, mepc for mret.
     - If both are asserted, the trap wins.
  2. dmem_busy:
     - Next state MEM_WAIT.
     - All en_* = 0; pc_en = 0; no flush.
  3. branch_redirect:
     - redirect_valid = 1 with redirect_pc = branch_target this cycle.
     - flush_fd = 1, flush_de = 1; en_em = en_mw = 1; pc_en = 1.
     - Stay in RUN.
  4. load_use_hazard:
     - pc_en = 0, en_fd = 0, flush_de = 1 (bubble); en_em = en_mw = 1.
  5. ifetch_busy:
     - pc_en = 0; flush_fd = 1; en_de, en_em and en_mw = 1.
  6. Otherwise: all en_* = 1, pc_en = 1, all flush_* = 0.
- MEM_WAIT:
  - All en_* = 0; pc_en = 0.
  - Return to RUN on the first cycle with dmem_busy = 0. That cycle already uses the RUN output decode.
  - trap_valid is ignored here; the writeback stage is frozen.
- DRAIN:
  - All flush_* = 1; all en_* = 0; pc_en = 0.
  - The counter increments only while dmem_busy = 0.
  - When the counter reaches DRAIN_CYCLES-1 with dmem_busy = 0, clear it and go to REDIRECT.
- REDIRECT:
  - redirect_valid = 1 and redirect_pc = the latched target, for exactly one cycle.
  - pc_en = 1; all flush_* = 1.
  - Next state RUN.
- Inputs not listed for a state are ignored in that state.
- A trap or mret arriving in DRAIN or REDIRECT is ignored; it cannot occur because writeback is flushed.
- busy = (state != RUN).
- redirect_pc holds its last driven value whenever redirect_valid = 0.
- Reset mid-sequence aborts the sequence immediately and asynchronously; no redirect is issued.

Test Plan:
- Reset: assert rst=0 mid-DRAIN -> immediately all flush_*=1, en_*=0, busy=0; after release, first edge gives en_*=1, pc_en=1.
- Load-use: pulse load_use_hazard for 1 cycle in RUN -> same cycle pc_en=0, en_fd=0, flush_de=1, en_em=1; next cycle all en_*=1.
- Mem wait: dmem_busy high 3 cycles -> 3 cycles of all en_*=0; branch_redirect asserted in cycle 2 produces no redirect_valid.
- Branch: branch_redirect=1, branch_target=0x8000_0100 -> same cycle redirect_valid=1, redirect_pc=0x8000_0100, flush_fd=flush_de=1.
- Trap drain: trap_valid with trap_pc=0x8000_0040, cause=0x0004, mtvec=0x8000_0000, dmem_busy high 2 cycles, DRAIN_CYCLES=2 ->
  - epc_out=0x8000_0040, cause_out=0x0004;
  - DRAIN lasts 4 cycles;
  - then exactly 1 cycle of redirect_valid=1, redirect_pc=0x8000_0000.
- Simultaneous: trap_valid and mret_valid together with mepc=0x8000_2000 -> redirect_pc=mtvec; cause_out is updated.
